axis_keep_unpacker: RTL and testbench

Unpacks a wide AXI-Stream carrying per-byte `tkeep` into a one-byte AXI-Stream, emitting only the bytes marked valid. It is the receive-side counterpart of the narrow-to-wide packer. That packer zero-pads the final word on an early `tlast`; this block uses `tkeep` to strip that padding so the original byte count is recovered. It sits between wide datapath blocks (FIFOs, DMA, MAC) and byte-serial consumers (parsers, UART/SPI framers). It runs at full throughput: one output byte per cycle with no inter-word bubbles.

---
 rtl/axis_pkg.sv | 30 +++
 rtl/axis_lane_select.sv | 32 +++
 rtl/axis_keep_unpacker.sv | 72 +++++++
 tb/tb_axis_keep_unpacker.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// Shared AXI-Stream helpers: byte width and keep-mask utilities used by the
// packer and unpacker. Masks are handled at MAX_LANES width; callers cast.
package axis_pkg;

   localparam int unsigned BYTE_W    = 8;
   localparam int unsigned MAX_LANES = 64;

   // One-hot of the lowest (or, with msb_first, highest) set bit of mask.
   function automatic logic [MAX_LANES-1:0] onehot_first(
      input logic [MAX_LANES-1:0] mask,
      input logic                 msb_first
   );
      logic [MAX_LANES-1:0] v_src;
      logic [MAX_LANES-1:0] v_low;
      logic [MAX_LANES-1:0] v_res;
      for (int i = 0; i < int'(MAX_LANES); i++) begin
         v_src[i] = msb_first ? mask[int'(MAX_LANES)-1-i] : mask[i];
      end
      v_low = v_src & (~v_src + MAX_LANES'(1));
      for (int i = 0; i < int'(MAX_LANES); i++) begin
         v_res[i] = msb_first ? v_low[int'(MAX_LANES)-1-i] : v_low[i];
      end
      return v_res;
   endfunction

   function automatic logic is_onehot(input logic [MAX_LANES-1:0] mask);
      return (mask != '0) && ((mask & (mask - MAX_LANES'(1))) == '0);
   endfunction

endpackage

// File: rtl/axis_lane_select.sv
// Picks the next byte lane to emit from the remaining-lane mask and flags
// when that lane is the final one held.
module axis_lane_select
   import axis_pkg::*;
#(
   parameter int unsigned LANES     = 4,
   parameter bit          MSB_FIRST = 1'b0
) (
   input  logic [LANES*BYTE_W-1:0] i_data,
   input  logic [LANES-1:0]        i_rem,
   output logic [BYTE_W-1:0]       o_byte,
   output logic [LANES-1:0]        o_sel,
   output logic                    o_last_lane
);

   logic [MAX_LANES-1:0] w_rem_ext;

   assign w_rem_ext   = MAX_LANES'(i_rem);
   assign o_sel       = LANES'(onehot_first(w_rem_ext, MSB_FIRST));
   assign o_last_lane = is_onehot(w_rem_ext);

   // AND-OR mux driven by the one-hot select
   always_comb begin
      o_byte = '0;
      for (int k = 0; k < int'(LANES); k++) begin
         if (o_sel[k]) begin
            o_byte = o_byte | i_data[k*int'(BYTE_W) +: int'(BYTE_W)];
         end
      end
   end

endmodule

// File: rtl/axis_keep_unpacker.sv
// Wide-to-byte AXI-Stream unpacker: emits only tkeep-marked lanes, one byte
// per cycle, reloading the next beat as the last held byte leaves.
module axis_keep_unpacker
   import axis_pkg::*;
#(
   parameter int unsigned AXIS_I_BYTES = 4,
   parameter bit          MSB_FIRST    = 1'b0
) (
   input  logic                           clk,
   input  logic                           sreset,
   output logic                           axis_i_tready,
   input  logic                           axis_i_tvalid,
   input  logic                           axis_i_tlast,
   input  logic [AXIS_I_BYTES-1:0]        axis_i_tkeep,
   input  logic [AXIS_I_BYTES*BYTE_W-1:0] axis_i_tdata,
   input  logic                           axis_o_tready,
   output logic                           axis_o_tvalid,
   output logic                           axis_o_tlast,
   output logic [BYTE_W-1:0]              axis_o_tdata,
   output logic                           null_last
);

   localparam int unsigned DATA_W = AXIS_I_BYTES * BYTE_W;

   logic [DATA_W-1:0]       r_data;
   logic [AXIS_I_BYTES-1:0] r_rem;
   logic                    r_last;
   logic                    r_null_last;

   logic [AXIS_I_BYTES-1:0] w_sel;
   logic                    w_last_lane;
   logic                    w_in_hs;
   logic                    w_out_hs;

   axis_lane_select #(
      .LANES     (AXIS_I_BYTES),
      .MSB_FIRST (MSB_FIRST)
   ) u_lane_select (
      .i_data      (r_data),
      .i_rem       (r_rem),
      .o_byte      (axis_o_tdata),
      .o_sel       (w_sel),
      .o_last_lane (w_last_lane)
   );

   // Ready when empty or when the final held byte drains this cycle
   assign axis_i_tready = !sreset && ((r_rem == '0) || (w_last_lane && axis_o_tready));
   assign axis_o_tvalid = (r_rem != '0);
   assign axis_o_tlast  = r_last && w_last_lane;
   assign null_last     = r_null_last;

   assign w_in_hs  = axis_i_tvalid && axis_i_tready;
   assign w_out_hs = axis_o_tvalid && axis_o_tready;

   always_ff @(posedge clk) begin
      if (sreset) begin
         r_rem       <= '0;
         r_last      <= 1'b0;
         r_null_last <= 1'b0;
      end else begin
         r_null_last <= w_in_hs && axis_i_tlast && (axis_i_tkeep == '0);
         if (w_in_hs) begin
            r_data <= axis_i_tdata;
            r_rem  <= axis_i_tkeep;
            r_last <= axis_i_tlast;
         end else if (w_out_hs) begin
            r_rem <= r_rem & ~w_sel;
         end
      end
   end

endmodule

// File: tb/tb_axis_keep_unpacker.sv
// Bench for axis_keep_unpacker: LSB-first and MSB-first instances share one
// input stream and are scored against a per-instance kept-byte queue model.
module tb_axis_keep_unpacker;

   typedef struct packed {
      logic [7:0] d;
      logic       l;
   } ent_t;

   logic        clk;
   logic        sreset;
   logic        i_tvalid;
   logic        i_tlast;
   logic [3:0]  i_tkeep;
   logic [31:0] i_tdata;
   logic        o_tready;
   logic        rand_mode;

   logic [1:0]  i_tready;
   logic [1:0]  o_tvalid;
   logic [1:0]  o_tlast;
   logic [1:0]  null_last;
   logic [7:0]  o_tdata [2];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   axis_keep_unpacker #(.AXIS_I_BYTES(4), .MSB_FIRST(1'b0)) u_dut_lsb (
      .clk(clk), .sreset(sreset), .axis_i_tready(i_tready[0]), .axis_i_tvalid(i_tvalid),
      .axis_i_tlast(i_tlast), .axis_i_tkeep(i_tkeep), .axis_i_tdata(i_tdata),
      .axis_o_tready(o_tready), .axis_o_tvalid(o_tvalid[0]), .axis_o_tlast(o_tlast[0]),
      .axis_o_tdata(o_tdata[0]), .null_last(null_last[0])
   );

   axis_keep_unpacker #(.AXIS_I_BYTES(4), .MSB_FIRST(1'b1)) u_dut_msb (
      .clk(clk), .sreset(sreset), .axis_i_tready(i_tready[1]), .axis_i_tvalid(i_tvalid),
      .axis_i_tlast(i_tlast), .axis_i_tkeep(i_tkeep), .axis_i_tdata(i_tdata),
      .axis_o_tready(o_tready), .axis_o_tvalid(o_tvalid[1]), .axis_o_tlast(o_tlast[1]),
      .axis_o_tdata(o_tdata[1]), .null_last(null_last[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1 o_tready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Reference model: kept bytes of each accepted beat in emission order
   for (genvar g = 0; g < 2; g++) begin : g_mon
      ent_t       q[$];
      logic       exp_null = 1'b0;
      logic       was_rst  = 1'b0;
      logic       stalled  = 1'b0;
      logic [7:0] st_d;
      logic       st_l;

      always @(negedge clk) begin
         if (sreset) begin
            check("rst_itready", 32'(i_tready[g]), 32'd0);
            if (was_rst) begin
               check("rst_ovalid", 32'(o_tvalid[g]), 32'd0);
               check("rst_olast", 32'(o_tlast[g]), 32'd0);
               check("rst_null", 32'(null_last[g]), 32'd0);
            end
            q.delete();
            exp_null = 1'b0;
            stalled  = 1'b0;
            was_rst  = 1'b1;
         end else begin
            was_rst = 1'b0;
            check("null_last", 32'(null_last[g]), 32'(exp_null));
            check("ovalid", 32'(o_tvalid[g]), 32'(q.size() != 0));
            if (stalled) begin
               check("stall_data", 32'(o_tdata[g]), 32'(st_d));
               check("stall_last", 32'(o_tlast[g]), 32'(st_l));
            end
            stalled = o_tvalid[g] && !o_tready;
            st_d    = o_tdata[g];
            st_l    = o_tlast[g];
            if (o_tvalid[g] && o_tready) begin
               if (q.size() == 0) begin
                  check("extra_byte", 32'(o_tvalid[g]), 32'd0);
               end else begin
                  ent_t e;
                  e = q.pop_front();
                  check("data", 32'(o_tdata[g]), 32'(e.d));
                  check("last", 32'(o_tlast[g]), 32'(e.l));
               end
            end
            exp_null = 1'b0;
            if (i_tvalid && i_tready[g]) begin
               int n_kept;
               n_kept   = 0;
               exp_null = i_tlast && (i_tkeep == 4'b0000);
               for (int k = 0; k < 4; k++) begin
                  int lane;
                  lane = (g == 1) ? 3 - k : k;
                  if (i_tkeep[lane]) begin
                     q.push_back('{d: i_tdata[lane*8 +: 8], l: 1'b0});
                     n_kept++;
                  end
               end
               if (i_tlast && n_kept > 0) q[q.size()-1].l = 1'b1;
            end
         end
      end
   end

   task automatic send_beat(input logic [31:0] data, input logic [3:0] keep, input logic last);
      int n;
      @(posedge clk);
      #1;
      i_tdata  = data;
      i_tkeep  = keep;
      i_tlast  = last;
      i_tvalid = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!i_tready[0] && n < 200);
      if (!i_tready[0]) check("in_timeout", 32'(i_tready[0]), 32'd1);
      @(posedge clk);
      #1 i_tvalid = 1'b0;
   endtask

   initial begin
      logic [7:0] exp_b [4];
      int n;
      sreset    = 1'b1;
      rand_mode = 1'b0;
      o_tready  = 1'b1;
      i_tvalid  = 1'b0;
      i_tlast   = 1'b0;
      i_tkeep   = '0;
      i_tdata   = '0;
      repeat (3) @(posedge clk);
      #1 sreset = 1'b0;
      @(negedge clk);
      check("post_rst_itready", 32'(i_tready[0]), 32'd1);
      check("post_rst_ovalid", 32'(o_tvalid[0]), 32'd0);

      // Full word, LSB first, tready back on the final byte
      exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
      send_beat(32'h44332211, 4'b1111, 1'b1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("t1_data", 32'(o_tdata[0]), 32'(exp_b[i]));
         check("t1_last", 32'(o_tlast[0]), 32'(i == 3));
         check("t1_itready", 32'(i_tready[0]), 32'(i == 3));
      end

      // Padding strip
      send_beat(32'h00002211, 4'b0011, 1'b1);
      @(negedge clk);
      check("t2_b0", 32'(o_tdata[0]), 32'h11);
      check("t2_l0", 32'(o_tlast[0]), 32'd0);
      @(negedge clk);
      check("t2_b1", 32'(o_tdata[0]), 32'h22);
      check("t2_l1", 32'(o_tlast[0]), 32'd1);
      @(negedge clk);
      check("t2_idle", 32'(o_tvalid[0]), 32'd0);

      // Sparse keep in both lane orders, then a dropped empty beat
      send_beat(32'hDDCCBBAA, 4'b1010, 1'b0);
      @(negedge clk);
      check("t3_msb0", 32'(o_tdata[1]), 32'hDD);
      check("t3_lsb0", 32'(o_tdata[0]), 32'hBB);
      @(negedge clk);
      check("t3_msb1", 32'(o_tdata[1]), 32'hBB);
      check("t3_lsb1", 32'(o_tdata[0]), 32'hDD);
      send_beat(32'h12345678, 4'b0000, 1'b0);
      @(negedge clk);
      check("t3_drop_valid", 32'(o_tvalid), 32'd0);
      check("t3_drop_null", 32'(null_last), 32'd0);

      // Null last pulse
      send_beat(32'hCAFEF00D, 4'b0000, 1'b1);
      @(negedge clk);
      check("null_pulse", 32'(null_last), 32'b11);
      check("null_valid", 32'(o_tvalid), 32'd0);
      @(negedge clk);
      check("null_clear", 32'(null_last), 32'd0);

      // Reset after two of four bytes
      send_beat(32'hA4A3A2A1, 4'b1111, 1'b1);
      @(negedge clk);
      @(negedge clk);
      check("rst_mid_byte1", 32'(o_tdata[0]), 32'hA2);
      @(posedge clk);
      #1 sreset = 1'b1;
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      check("rst_hold_valid", 32'(o_tvalid), 32'd0);
      @(posedge clk);
      #1 sreset = 1'b0;
      @(negedge clk);
      check("rst_rel_itready", 32'(i_tready), 32'b11);
      check("rst_rel_valid", 32'(o_tvalid), 32'd0);
      exp_b = '{8'h55, 8'h66, 8'h77, 8'h88};
      send_beat(32'h88776655, 4'b1111, 1'b1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("rst_next_data", 32'(o_tdata[0]), 32'(exp_b[i]));
      end

      // Random beats under random output backpressure
      rand_mode = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 1000;) begin
         i_tvalid = ($urandom_range(0, 3) != 0);
         i_tdata  = $urandom;
         i_tkeep  = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom);
         i_tlast  = 1'($urandom);
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (i_tvalid && !i_tready[0] && n < 200);
         if (i_tvalid) begin
            if (!i_tready[0]) check("rand_in_timeout", 32'(i_tready[0]), 32'd1);
            i++;
         end
         @(posedge clk);
         #1;
      end
      i_tvalid  = 1'b0;
      rand_mode = 1'b0;
      n = 0;
      while ((g_mon[0].q.size() != 0 || g_mon[1].q.size() != 0) && n < 500) begin
         @(posedge clk);
         n++;
      end
      @(negedge clk);
      check("drain_lsb", 32'(g_mon[0].q.size()), 32'd0);
      check("drain_msb", 32'(g_mon[1].q.size()), 32'd0);
      check("drain_valid", 32'(o_tvalid), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
